// File: rtl/coord_scaler_if.sv
`default_nettype none
// ============================================================================
// Module      : coord_scaler_if
// Description : Request/result bundle for the coordinate scaler. The master
//               side issues a conversion request; the slave side returns the
//               scaled coordinates and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface coord_scaler_if #(
   parameter int IN_W  = 11,
   parameter int OUT_W = 13
);
   logic             start;
   logic [IN_W-1:0]  x;
   logic [IN_W-1:0]  y;
   logic [IN_W-1:0]  t_width;
   logic [IN_W-1:0]  t_height;
   logic [OUT_W-1:0] cv_x;
   logic [OUT_W-1:0] cv_y;
   logic             busy;
   logic             done;
   logic             ovf_x;
   logic             ovf_y;
   logic             div0;

   modport master (
      output start, x, y, t_width, t_height,
      input  cv_x, cv_y, busy, done, ovf_x, ovf_y, div0
   );

   modport slave (
      input  start, x, y, t_width, t_height,
      output cv_x, cv_y, busy, done, ovf_x, ovf_y, div0
   );
endinterface
`default_nettype wire

// File: rtl/coord_scaler.sv
`default_nettype none
// ============================================================================
// Module      : coord_scaler
// Description : Maps a point (x, y) to a scaled coordinate pair relative to a
//               fixed centre: cv = |coord - centre| * SCALE / target. One
//               serial restoring divider is shared between the two axes, so a
//               conversion takes 2*PROD_W+2 cycles from the accepting edge.
//               Results saturate (magnitude or two's-complement form) and a
//               zero divisor forces the saturated value with div0 raised.
// Revision    : 1.0 - initial release
// ============================================================================
module coord_scaler #(
   parameter int IN_W       = 11,
   parameter int SCALE_W    = 10,
   parameter int OUT_W      = 13,
   parameter int CX         = 262,
   parameter int CY         = 262,
   parameter int SCALE_X    = 525,
   parameter int SCALE_Y    = 525,
   parameter int SIGNED_OUT = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   coord_scaler_if.slave bus
);

   localparam int PROD_W  = IN_W + SCALE_W;
   localparam int c_CNT_W = $clog2(PROD_W);

   localparam logic [IN_W-1:0]    c_CX   = IN_W'(CX);
   localparam logic [IN_W-1:0]    c_CY   = IN_W'(CY);
   localparam logic [SCALE_W-1:0] c_SX   = SCALE_W'(SCALE_X);
   localparam logic [SCALE_W-1:0] c_SY   = SCALE_W'(SCALE_Y);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PROD_W - 1);

   // Largest magnitude representable on the output in the selected format.
   localparam logic [PROD_W-1:0] c_MAG_MAX = (SIGNED_OUT != 0)
      ? PROD_W'((64'd1 << (OUT_W - 1)) - 64'd1)
      : PROD_W'((64'd1 << OUT_W) - 64'd1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PREP  = 3'd1,
      S_DIV_X = 3'd2,
      S_DIV_Y = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t r_state;
   state_t w_state_nx;

   // Operands captured when a request is accepted
   logic [IN_W-1:0]   r_x;
   logic [IN_W-1:0]   r_y;
   logic [IN_W-1:0]   r_tw;
   logic [IN_W-1:0]   r_th;

   // Per-axis sign and the y product parked while x is divided
   logic              r_neg_x;
   logic              r_neg_y;
   logic [PROD_W-1:0] r_prod_y;

   // Shared divider: r_dvd shifts the dividend out at the top while quotient
   // bits enter at the bottom, so after PROD_W steps it holds the quotient.
   logic [PROD_W-1:0]  r_dvd;
   logic [IN_W-1:0]    r_rem;
   logic [c_CNT_W-1:0] r_cnt;
   logic [PROD_W-1:0]  r_qx;

   // Result registers
   logic [OUT_W-1:0]  r_cv_x;
   logic [OUT_W-1:0]  r_cv_y;
   logic              r_ovf_x;
   logic              r_ovf_y;
   logic              r_div0;

   logic [IN_W-1:0]   w_d;
   logic [IN_W-1:0]   w_e;
   logic              w_neg_x;
   logic              w_neg_y;
   logic [PROD_W-1:0] w_prod_x;
   logic [PROD_W-1:0] w_prod_y;
   logic [IN_W-1:0]   w_divisor;
   logic [IN_W:0]     w_rem_sh;
   logic              w_ge;
   logic [IN_W-1:0]   w_rem_nx;
   logic [PROD_W-1:0] w_dvd_nx;
   logic              w_last;
   logic [OUT_W:0]    w_res_x;
   logic [OUT_W:0]    w_res_y;

   // Clamp a quotient to the output range, apply the axis sign in signed
   // mode, and report whether the value was clamped. A zero divisor always
   // yields the clamped maximum.
   function automatic logic [OUT_W:0] f_scale_out(
      input logic [PROD_W-1:0] q,
      input logic              neg,
      input logic              dz
   );
      logic              ovf;
      logic [PROD_W-1:0] mag;
      logic [OUT_W-1:0]  res;
      ovf = dz || (q > c_MAG_MAX);
      mag = ovf ? c_MAG_MAX : q;
      res = mag[OUT_W-1:0];
      if ((SIGNED_OUT != 0) && neg) begin
         res = -res;
      end
      return {ovf, res};
   endfunction

   // Centre offsets, signs and products from the captured coordinates
   always_comb begin
      w_neg_x  = (r_x < c_CX);
      w_neg_y  = (r_y < c_CY);
      w_d      = w_neg_x ? (c_CX - r_x) : (r_x - c_CX);
      w_e      = w_neg_y ? (c_CY - r_y) : (r_y - c_CY);
      w_prod_x = {{SCALE_W{1'b0}}, w_d} * {{IN_W{1'b0}}, c_SX};
      w_prod_y = {{SCALE_W{1'b0}}, w_e} * {{IN_W{1'b0}}, c_SY};
   end

   // One restoring-division step: shift in the next dividend bit, subtract
   // the divisor when it fits and record the resulting quotient bit.
   always_comb begin
      w_divisor = (r_state == S_DIV_Y) ? r_th : r_tw;
      w_rem_sh  = {r_rem, r_dvd[PROD_W-1]};
      w_ge      = (w_rem_sh >= {1'b0, w_divisor});
      w_rem_nx  = w_ge ? IN_W'(w_rem_sh - {1'b0, w_divisor}) : w_rem_sh[IN_W-1:0];
      w_dvd_nx  = {r_dvd[PROD_W-2:0], w_ge};
      w_last    = (r_cnt == c_LAST);
   end

   // Final per-axis results; the y quotient is taken from the last step
   always_comb begin
      w_res_x = f_scale_out(r_qx, r_neg_x, (r_tw == '0));
      w_res_y = f_scale_out(w_dvd_nx, r_neg_y, (r_th == '0));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state logic: fixed sequence, each divide phase lasts PROD_W cycles
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nx = S_PREP;
         S_PREP:  w_state_nx = S_DIV_X;
         S_DIV_X: if (w_last) w_state_nx = S_DIV_Y;
         S_DIV_Y: if (w_last) w_state_nx = S_DONE;
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Operand capture, product preparation and the shared divider
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x      <= '0;
         r_y      <= '0;
         r_tw     <= '0;
         r_th     <= '0;
         r_neg_x  <= 1'b0;
         r_neg_y  <= 1'b0;
         r_prod_y <= '0;
         r_dvd    <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_qx     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_x  <= bus.x;
                  r_y  <= bus.y;
                  r_tw <= bus.t_width;
                  r_th <= bus.t_height;
               end
            end
            S_PREP: begin
               r_neg_x  <= w_neg_x;
               r_neg_y  <= w_neg_y;
               r_dvd    <= w_prod_x;
               r_prod_y <= w_prod_y;
               r_rem    <= '0;
               r_cnt    <= '0;
            end
            S_DIV_X: begin
               if (w_last) begin
                  // x quotient complete: park it and restart on the y product
                  r_qx  <= w_dvd_nx;
                  r_dvd <= r_prod_y;
                  r_rem <= '0;
                  r_cnt <= '0;
               end else begin
                  r_dvd <= w_dvd_nx;
                  r_rem <= w_rem_nx;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DIV_Y: begin
               r_dvd <= w_dvd_nx;
               r_rem <= w_rem_nx;
               r_cnt <= r_cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Result registers load on the last y step so they are valid with done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cv_x  <= '0;
         r_cv_y  <= '0;
         r_ovf_x <= 1'b0;
         r_ovf_y <= 1'b0;
         r_div0  <= 1'b0;
      end else if ((r_state == S_DIV_Y) && w_last) begin
         r_cv_x  <= w_res_x[OUT_W-1:0];
         r_ovf_x <= w_res_x[OUT_W];
         r_cv_y  <= w_res_y[OUT_W-1:0];
         r_ovf_y <= w_res_y[OUT_W];
         r_div0  <= (r_tw == '0) || (r_th == '0);
      end
   end

   assign bus.busy  = (r_state != S_IDLE);
   assign bus.done  = (r_state == S_DONE);
   assign bus.cv_x  = r_cv_x;
   assign bus.cv_y  = r_cv_y;
   assign bus.ovf_x = r_ovf_x;
   assign bus.ovf_y = r_ovf_y;
   assign bus.div0  = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_coord_scaler.sv
`default_nettype none
// ============================================================================
// Module      : tb_coord_scaler
// Description : Bench for coord_scaler. Two instances (magnitude and signed
//               output) receive identical stimulus; results are compared
//               against an arithmetic reference model of the scaling rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coord_scaler;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [10:0] x;
   logic [10:0] y;
   logic [10:0] tw;
   logic [10:0] th;

   int n_vec;
   int n_err;

   coord_scaler_if #(.IN_W(11), .OUT_W(13)) bus_u ();
   coord_scaler_if #(.IN_W(11), .OUT_W(13)) bus_s ();

   assign bus_u.start    = start;
   assign bus_u.x        = x;
   assign bus_u.y        = y;
   assign bus_u.t_width  = tw;
   assign bus_u.t_height = th;
   assign bus_s.start    = start;
   assign bus_s.x        = x;
   assign bus_s.y        = y;
   assign bus_s.t_width  = tw;
   assign bus_s.t_height = th;

   coord_scaler #(.SIGNED_OUT(0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));
   coord_scaler #(.SIGNED_OUT(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference for one axis: scaled offset from the 262 centre, divided,
   // clamped to the output range and signed when requested.
   function automatic void model_axis(input int c, input int t, input bit sgn,
                                      output logic [12:0] v, output bit o);
      int dlt, mag, lim, q;
      dlt = c - 262;
      mag = ((dlt < 0) ? -dlt : dlt) * 525;
      lim = sgn ? 4095 : 8191;
      if (t == 0) begin
         q = lim;
         o = 1'b1;
      end else begin
         q = mag / t;
         o = (q > lim);
         if (o) q = lim;
      end
      if (sgn && dlt < 0) q = -q;
      v = 13'(q);
   endfunction

   task automatic chk_outputs(input string pfx, input bit sgn,
                              input int ax, ay, atw, ath);
      logic [12:0] ex, ey;
      bit ox, oy, dz;
      model_axis(ax, atw, sgn, ex, ox);
      model_axis(ay, ath, sgn, ey, oy);
      dz = (atw == 0) || (ath == 0);
      if (!sgn) begin
         chk({pfx, "u_cv_x"}, bus_u.cv_x, ex);
         chk({pfx, "u_cv_y"}, bus_u.cv_y, ey);
         chk({pfx, "u_ovf_x"}, bus_u.ovf_x, ox);
         chk({pfx, "u_ovf_y"}, bus_u.ovf_y, oy);
         chk({pfx, "u_div0"}, bus_u.div0, dz);
      end else begin
         chk({pfx, "s_cv_x"}, bus_s.cv_x, ex);
         chk({pfx, "s_cv_y"}, bus_s.cv_y, ey);
         chk({pfx, "s_ovf_x"}, bus_s.ovf_x, ox);
         chk({pfx, "s_ovf_y"}, bus_s.ovf_y, oy);
         chk({pfx, "s_div0"}, bus_s.div0, dz);
      end
   endtask

   // One conversion with a single-cycle start; optionally scrambles the
   // inputs while busy, which must not affect the result.
   task automatic run_conv(input int ax, ay, atw, ath, input bit scramble);
      int  n;
      bit  seen;
      @(negedge clk);
      x = 11'(ax); y = 11'(ay); tw = 11'(atw); th = 11'(ath);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy", bus_u.busy, 1);
      n = 1;
      seen = 1'b0;
      while (!seen && n < 60) begin
         @(negedge clk);
         if (scramble) begin
            x = 11'($urandom); y = 11'($urandom);
            tw = 11'($urandom); th = 11'($urandom);
         end
         @(posedge clk); #1;
         n++;
         if (bus_u.done) seen = 1'b1;
      end
      chk("latency", n, 44);
      chk("s_done", bus_s.done, 1);
      chk_outputs("", 1'b0, ax, ay, atw, ath);
      chk_outputs("", 1'b1, ax, ay, atw, ath);
      @(posedge clk); #1;
      chk("done_pulse", bus_u.done, 0);
      chk("idle", bus_u.busy, 0);
      chk_outputs("hold_", 1'b0, ax, ay, atw, ath);
   endtask

   function automatic int rand_div();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 0;
      if (r < 4) return $urandom_range(1, 20);
      return $urandom_range(1, 2047);
   endfunction

   // Main sequence
   initial begin
      int dn;
      int bx, by, btw, bth;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0;
      x = '0; y = '0; tw = '0; th = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus_u.busy, 0);
      chk("rst_done", bus_u.done, 0);
      chk("rst_cv_x", bus_u.cv_x, 0);
      chk("rst_cv_y", bus_s.cv_y, 0);
      chk("rst_div0", bus_u.div0, 0);
      rst_n = 1'b1;

      // Directed cases: nominal, overflow, divide-by-zero
      run_conv(400, 100, 100, 50, 1'b1);
      run_conv(2047, 262, 1, 7, 1'b0);
      run_conv(300, 262, 10, 0, 1'b1);
      run_conv(0, 2047, 0, 1, 1'b0);

      // Randomized conversions
      for (int i = 0; i < 12; i++) begin
         run_conv($urandom_range(0, 2047), $urandom_range(0, 2047),
                  rand_div(), rand_div(), 1'b1);
      end

      // start held high for 50 edges with inputs changed mid-conversion
      bx = $urandom_range(0, 2047); by = $urandom_range(0, 2047);
      btw = $urandom_range(1, 300); bth = $urandom_range(1, 300);
      dn = 0;
      @(negedge clk);
      x = 11'd400; y = 11'd100; tw = 11'd100; th = 11'd50;
      start = 1'b1;
      for (int e = 1; e <= 100; e++) begin
         @(posedge clk); #1;
         if (bus_u.done) begin
            dn++;
            if (dn == 1) begin
               chk("held_lat1", e, 44);
               chk_outputs("held1_", 1'b0, 400, 100, 100, 50);
               chk_outputs("held1_", 1'b1, 400, 100, 100, 50);
            end else if (dn == 2) begin
               chk("held_lat2", e, 89);
               chk_outputs("held2_", 1'b0, bx, by, btw, bth);
               chk_outputs("held2_", 1'b1, bx, by, btw, bth);
            end
         end
         @(negedge clk);
         if (e == 10) begin
            x = 11'(bx); y = 11'(by); tw = 11'(btw); th = 11'(bth);
         end
         if (e == 50) start = 1'b0;
      end
      chk("held_dones", dn, 2);

      // Reset in the middle of a conversion
      @(negedge clk);
      x = 11'd400; y = 11'd100; tw = 11'd100; th = 11'd50;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", bus_u.busy, 0);
      chk("mid_rst_done", bus_u.done, 0);
      chk("mid_rst_cv_x", bus_u.cv_x, 0);
      chk("mid_rst_cv_y", bus_s.cv_y, 0);
      chk("mid_rst_ovf", {bus_u.ovf_x, bus_u.ovf_y, bus_u.div0}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int e = 0; e < 50; e++) begin
         @(posedge clk); #1;
         if (bus_u.done || bus_s.done) dn++;
      end
      chk("mid_rst_no_done", dn, 0);
      run_conv(400, 100, 100, 50, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/coord_scaler.md
COORD_SCALER -- requirements
Module: coord_scaler

Interface
REQ-001 SHALL have parameter IN_W, default 11: width of x, y, t_width, t_height.
REQ-002 SHALL have parameter SCALE_W, default 10: width of SCALE_X and SCALE_Y.
REQ-003 SHALL have parameter OUT_W, default 13: width of cv_x and cv_y.
REQ-004 SHALL have parameters CX and CY, default 262 each: centre of the reference frame.
REQ-005 SHALL have parameters SCALE_X and SCALE_Y, default 525 each: per-axis scale numerators.
REQ-006 SHALL have parameter SIGNED_OUT, default 0: 0 gives magnitude output; 1 gives two's-complement output.
REQ-007 SHALL define localparam PROD_W = IN_W + SCALE_W (21 at defaults).
REQ-008 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have port start, input, 1 bit: request a conversion.
REQ-011 SHALL have ports x and y, inputs, IN_W bits each: point coordinates.
REQ-012 SHALL have ports t_width and t_height, inputs, IN_W bits each: target divisors.
REQ-013 SHALL have ports cv_x and cv_y, outputs, OUT_W bits each: scaled results.
REQ-014 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle result-valid strobe.
REQ-016 SHALL have ports ovf_x, ovf_y and div0, outputs, 1 bit each: status flags, valid when done=1.

Function
REQ-017 SHALL implement FSM IDLE -> PREP -> DIV_X -> DIV_Y -> DONE -> IDLE; busy=1 in every state except IDLE.
REQ-018 SHALL, in IDLE with start=1, register x, y, t_width and t_height, then go to PREP; start SHALL be ignored in all other states.
REQ-019 SHALL, in PREP: form d = |x-CX| and e = |y-CY| (IN_W bits); record each sign (coord < centre is negative); form PROD_W-bit products d*SCALE_X and e*SCALE_Y.
REQ-020 SHALL use ONE shared serial restoring divider producing one quotient bit per cycle; DIV_X and DIV_Y SHALL each last exactly PROD_W cycles, quotient truncated toward zero.
REQ-021 SHALL, in DONE, update cv_x, cv_y and the flags, and drive done=1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-022 SHALL fix latency: with the start-sampling edge counted as edge 1, done is high after edge 2*PROD_W+2 (edge 44 at defaults).
REQ-023 SHALL accept a new start in the cycle after done (back-to-back operation).
REQ-024 SHALL saturate, when SIGNED_OUT=0, any quotient above 2^OUT_W-1 to 2^OUT_W-1 and set that axis's ovf flag.
REQ-025 SHALL, when SIGNED_OUT=1, clamp magnitude to 2^(OUT_W-1)-1, set ovf on clamp, and negate the result if the axis sign is negative.
REQ-026 SHALL treat a zero divisor (t_width or t_height) as follows: that axis outputs the saturated maximum magnitude, with sign per REQ-025; div0=1 and ovf for that axis=1; timing is unchanged.
REQ-027 SHALL hold cv_x, cv_y and the flags between completions; changes to inputs while busy SHALL have no effect.

Reset
REQ-028 SHALL, on rst_n=0 (any state, including mid-divide), immediately enter IDLE and clear cv_x, cv_y, busy, done, ovf_x, ovf_y, div0 and all datapath registers to 0.
REQ-029 SHALL, after rst_n deasserts, accept start on the first following rising edge.

Verification
REQ-030 SHALL cover nominal operation at defaults: x=400, y=100, t_width=100, t_height=50, start pulse -> done high after edge 44, cv_x=724, cv_y=1701, all flags 0.
REQ-031 SHALL cover SIGNED_OUT=1 with the same stimulus as REQ-030 -> cv_x=724, cv_y=-1701 (13'h195B), flags 0.
REQ-032 SHALL cover overflow: x=2047, y=262, t_width=1, t_height=7 -> cv_x=8191, ovf_x=1, cv_y=0, ovf_y=0.
REQ-033 SHALL cover divide-by-zero: t_height=0, x=300, t_width=10 -> cv_x=1995, cv_y=8191, div0=1, ovf_y=1.
REQ-034 SHALL cover start held high for 50 cycles with inputs changed mid-operation -> exactly one done per conversion, results computed from the inputs sampled at acceptance, second conversion accepted the cycle after done.
REQ-035 SHALL cover rst_n pulsed low at edge 20 of a conversion -> all outputs 0 immediately, no done strobe, a following conversion yields REQ-030 values.
